// File: rtl/mem_write_control.sv
// mem_write_control
//   Drains bytes from the upstream FIFO and writes them into the BRAM at
//   consecutive addresses. A start pulse latches the base address and the
//   transfer length. The block then alternates FIFO reads and BRAM writes,
//   at two cycles per word, until the length is exhausted. It pulses done
//   for one cycle when the transfer completes. An abort returns the block to
//   IDLE without a done pulse.
//
// Ports
//   clk_mem       in   memory-domain clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   start         in   begin a transfer (only honoured in IDLE)
//   abort         in   cancel the transfer; overrides every other input
//   base_addr     in   first BRAM write address, latched on start
//   xfer_len      in   number of words to move (0..2**ADDR_W), latched on start
//   fifo_empty    in   upstream FIFO empty flag
//   fifo_rd_data  in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    out  FIFO read strobe
//   bram_we       out  BRAM write enable
//   bram_addr     out  BRAM write address
//   bram_wdata    out  BRAM write data
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse on successful completion
//   wr_count      out  words written in the current or last transfer
module mem_write_control #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk_mem,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   xfer_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   remaining;

    // A write that is under way in the same cycle as an abort still
    // completes and is counted. Only the transition back to FETCH or DONE is
    // suppressed.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_reg  <= '0;
            remaining <= '0;
            wr_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        addr_reg  <= base_addr;
                        remaining <= xfer_len;
                        wr_count  <= '0;
                        state     <= (xfer_len != '0) ? FETCH : DONE;
                    end
                end
                FETCH: begin
                    if (abort)
                        state <= IDLE;
                    else if (!fifo_empty)
                        state <= WRITE;
                end
                WRITE: begin
                    addr_reg  <= addr_reg + ADDR_W'(1);
                    remaining <= remaining - (ADDR_W+1)'(1);
                    wr_count  <= wr_count + (ADDR_W+1)'(1);
                    if (abort)
                        state <= IDLE;
                    else if (remaining == (ADDR_W+1)'(1))
                        state <= DONE;
                    else
                        state <= FETCH;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The FIFO is popped in FETCH. Its data therefore arrives in WRITE and
    // goes straight through to the BRAM. Because the two strobes are decoded
    // from different states, they can never be high together.
    assign fifo_rd_en = (state == FETCH) && !fifo_empty;
    assign bram_we    = (state == WRITE);
    assign bram_addr  = addr_reg;
    assign bram_wdata = (state == WRITE) ? fifo_rd_data : '0;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_mem_write_control.sv
// tb_mem_write_control
//   Directed bench for mem_write_control. It contains a FIFO model that
//   feeds the DUT and a BRAM write log. The bench compares the log against
//   hand-computed addresses and data.
module tb_mem_write_control;

    logic       clk_mem;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [7:0] base_addr;
    logic [8:0] xfer_len;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic       bram_we;
    logic [7:0] bram_addr;
    logic [7:0] bram_wdata;
    logic       busy;
    logic       done;
    logic [8:0] wr_count;

    int checks = 0;
    int errors = 0;

    mem_write_control #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk_mem      (clk_mem),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .xfer_len     (xfer_len),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wdata   (bram_wdata),
        .busy         (busy),
        .done         (done),
        .wr_count     (wr_count)
    );

    initial clk_mem = 1'b0;
    always #5 clk_mem = ~clk_mem;

    // The FIFO model is an array with free-running pointers. Words are pushed
    // from the stimulus process and popped on fifo_rd_en.
    logic [7:0] fifoMem [0:1023];
    int         wrPtr = 0;
    int         rdPtr = 0;
    logic       forceEmpty = 1'b0;

    assign fifo_empty = forceEmpty || (rdPtr == wrPtr);

    initial fifo_rd_data = 8'h00;
    always @(posedge clk_mem) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fifoMem[rdPtr % 1024];
            rdPtr        <= rdPtr + 1;
        end
    end

    // Every BRAM write is logged, and every done pulse is counted.
    logic [7:0] logAddr [0:1023];
    logic [7:0] logData [0:1023];
    int         logN      = 0;
    int         doneCount = 0;
    int         overlap   = 0;

    always @(posedge clk_mem) begin
        if (bram_we) begin
            logAddr[logN % 1024] <= bram_addr;
            logData[logN % 1024] <= bram_wdata;
            logN                 <= logN + 1;
        end
        if (done)
            doneCount <= doneCount + 1;
    end

    always @(negedge clk_mem) begin
        if (fifo_rd_en && bram_we)
            overlap <= overlap + 1;
    end

    task automatic tick();
        @(posedge clk_mem);
        #1;
    endtask

    task automatic pushWord(input logic [7:0] d);
        fifoMem[wrPtr % 1024] = d;
        wrPtr = wrPtr + 1;
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] b, input logic [8:0] l);
        start     = s;
        base_addr = b;
        xfer_len  = l;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // The edge that samples start is counted as cycle 1. The task returns
    // the number of edges until done is seen, capped at bound.
    task automatic runUntilDone(input logic [7:0] b, input logic [8:0] l,
                                input int bound, output int cycles);
        applyStimulus(1'b1, b, l);
        tick();
        cycles = 1;
        start  = 1'b0;
        while (!done && cycles < bound) begin
            tick();
            cycles++;
        end
    endtask

    int cyc;
    int logStart;
    int doneStart;
    int bad;

    initial begin
        reset_n = 1'b0;
        abort   = 1'b0;
        applyStimulus(1'b0, 8'h00, 9'd0);
        tick();
        tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_wr_count", wr_count, 0);
        checkOutput("reset_bram_addr", bram_addr, 0);
        checkOutput("reset_strobes", {fifo_rd_en, bram_we}, 0);
        reset_n = 1'b1;
        tick();

        // base 0x10, len 4, data A1..A4: done arrives on edge 2*4+1.
        $display("[TB] basic transfer");
        pushWord(8'hA1); pushWord(8'hA2); pushWord(8'hA3); pushWord(8'hA4);
        logStart  = logN;
        doneStart = doneCount;
        runUntilDone(8'h10, 9'd4, 50, cyc);
        checkOutput("basic_done", done, 1);
        checkOutput("basic_cycles", cyc, 9);
        checkOutput("basic_wr_count", wr_count, 4);
        checkOutput("basic_writes", logN - logStart, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("basic_addr", logAddr[logStart + i], 32'h10 + i);
            checkOutput("basic_data", logData[logStart + i], 32'hA1 + i);
        end
        tick();
        checkOutput("basic_busy_after", busy, 0);
        checkOutput("basic_done_once", doneCount - doneStart, 1);

        // Address wrap across 0xFF -> 0x00.
        $display("[TB] address wrap");
        pushWord(8'h31); pushWord(8'h32); pushWord(8'h33);
        logStart = logN;
        runUntilDone(8'hFE, 9'd3, 50, cyc);
        checkOutput("wrap_cycles", cyc, 7);
        checkOutput("wrap_wr_count", wr_count, 3);
        tick();
        checkOutput("wrap_addr0", logAddr[logStart], 8'hFE);
        checkOutput("wrap_addr1", logAddr[logStart + 1], 8'hFF);
        checkOutput("wrap_addr2", logAddr[logStart + 2], 8'h00);
        checkOutput("wrap_data2", logData[logStart + 2], 8'h33);

        // FIFO held empty for 5 cycles after start; the block must wait.
        $display("[TB] empty stall");
        pushWord(8'h41); pushWord(8'h42);
        forceEmpty = 1'b1;
        logStart   = logN;
        doneStart  = doneCount;
        applyStimulus(1'b1, 8'h60, 9'd2);
        tick();
        start = 1'b0;
        bad   = 0;
        for (int i = 0; i < 5; i++) begin
            if (fifo_rd_en || bram_we) bad++;
            tick();
        end
        checkOutput("stall_no_strobes", bad, 0);
        checkOutput("stall_busy", busy, 1);
        forceEmpty = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("stall_resume_cycles", cyc, 4);
        tick();
        checkOutput("stall_writes", logN - logStart, 2);
        checkOutput("stall_data", {logData[logStart], logData[logStart + 1]}, 16'h4142);
        checkOutput("stall_done_once", doneCount - doneStart, 1);

        // Zero length: done follows the start edge directly, with no writes.
        $display("[TB] zero length");
        logStart = logN;
        runUntilDone(8'h55, 9'd0, 10, cyc);
        checkOutput("zero_cycles", cyc, 1);
        checkOutput("zero_wr_count", wr_count, 0);
        tick();
        checkOutput("zero_writes", logN - logStart, 0);
        checkOutput("zero_busy_after", busy, 0);

        // Abort during the write of word 2 of 5. A second start issued while
        // the block is busy is ignored.
        $display("[TB] abort and start-while-busy");
        pushWord(8'h51); pushWord(8'h52);
        logStart  = logN;
        doneStart = doneCount;
        applyStimulus(1'b1, 8'h20, 9'd5);
        tick();
        applyStimulus(1'b1, 8'h99, 9'd7);
        tick();
        applyStimulus(1'b0, 8'h99, 9'd7);
        tick();
        tick();
        abort = 1'b1;
        #1;
        checkOutput("abort_we", bram_we, 1);
        checkOutput("abort_addr", bram_addr, 8'h21);
        checkOutput("abort_wdata", bram_wdata, 8'h52);
        tick();
        abort = 1'b0;
        checkOutput("abort_idle", busy, 0);
        checkOutput("abort_wr_count", wr_count, 2);
        checkOutput("abort_addr_next", bram_addr, 8'h22);
        tick();
        checkOutput("abort_writes", logN - logStart, 2);
        checkOutput("abort_first_addr", logAddr[logStart], 8'h20);
        checkOutput("abort_no_done", doneCount - doneStart, 0);

        // A full 256-word transfer with the FIFO always supplied.
        $display("[TB] full 256-word transfer");
        for (int i = 0; i < 256; i++) pushWord(8'(i * 7 + 3));
        logStart = logN;
        runUntilDone(8'h00, 9'd256, 600, cyc);
        checkOutput("full_cycles", cyc, 513);
        checkOutput("full_wr_count", wr_count, 256);
        tick();
        checkOutput("full_writes", logN - logStart, 256);
        checkOutput("full_last_addr", logAddr[logStart + 255], 8'hFF);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (logAddr[logStart + i] !== 8'(i) || logData[logStart + i] !== 8'(i * 7 + 3))
                bad++;
        end
        checkOutput("full_contents", bad, 0);
        checkOutput("strobe_overlap", overlap, 0);

        // Asynchronous reset in the middle of a write.
        $display("[TB] reset mid-write");
        pushWord(8'h71); pushWord(8'h72);
        doneStart = doneCount;
        applyStimulus(1'b1, 8'h40, 9'd2);
        tick();
        start = 1'b0;
        tick();
        checkOutput("rst_in_write", bram_we, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async_outputs",
                    {busy, done, bram_we, fifo_rd_en, bram_addr, bram_wdata, wr_count}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("rst_idle", busy, 0);
        checkOutput("rst_no_done", doneCount - doneStart, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
